// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: opcodes, funct codes, MDU state encoding and decode helpers for hazard_ctrl
package hazard_ctrl_pkg;

    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] FN_MULT   = 6'h18;
    localparam logic [5:0] FN_MULTU  = 6'h19;
    localparam logic [5:0] FN_DIV    = 6'h1A;
    localparam logic [5:0] FN_DIVU   = 6'h1B;
    localparam logic [5:0] FN_MFHI   = 6'h10;
    localparam logic [5:0] FN_MFLO   = 6'h12;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;

    function automatic logic is_rtype_fn(input logic [31:0] ins, input logic [5:0] a, input logic [5:0] b);
        return (ins[31:26] == OP_RTYPE) && (ins[5:0] == a || ins[5:0] == b);
    endfunction

    function automatic logic is_div(input logic [31:0] ins);
        return is_rtype_fn(ins, FN_DIV, FN_DIVU);
    endfunction

    function automatic logic is_mdu(input logic [31:0] ins);
        return is_rtype_fn(ins, FN_MULT, FN_MULTU) || is_div(ins);
    endfunction

    function automatic logic is_mfhilo(input logic [31:0] ins);
        return is_rtype_fn(ins, FN_MFHI, FN_MFLO);
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// mdu_seq: tracks MDU occupancy after a mult/div leaves execute and pulses done once it drains
module mdu_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins_e,
    output logic        busy,
    output logic        done
);

    mdu_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (is_mdu(ins_e)) begin
                state_d = BUSY;
                cnt_d   = is_div(ins_e) ? 32'(DIV_CYCLES - 1) : 32'(MULT_CYCLES - 1);
            end
        end else if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end else begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign done = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use and MDU stall detection, branch flushing and a saturating stall counter
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins_d,
    input  logic [31:0] ins_e,
    input  logic        branch_taken_e,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cnt
);

    logic        load_use, mdu_hz, stall;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    mdu_seq #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu_seq (
        .clk  (clk),
        .reset(reset),
        .ins_e(ins_e),
        .busy (mdu_busy),
        .done (mdu_done)
    );

    always_comb begin
        load_use    = (ins_e[31:26] == OP_LW) && (ins_e[20:16] != 5'd0) &&
                      (ins_e[20:16] == ins_d[25:21] || ins_e[20:16] == ins_d[20:16]);
        mdu_hz      = (is_mdu(ins_d) || is_mfhilo(ins_d)) && mdu_busy;
        // a taken branch squashes the dependent instruction, so it overrides any stall
        stall       = (load_use || mdu_hz) && !branch_taken_e;
        stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_f   = stall;
    assign stall_d   = stall;
    assign flush_d   = branch_taken_e;
    assign flush_e   = stall || branch_taken_e;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ins_d = '0, ins_e = '0;
    logic        branch_taken_e = 1'b0;
    logic        stall_f, stall_d, flush_d, flush_e, mdu_busy, mdu_done;
    logic [31:0] stall_cnt;

    hazard_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .ins_d         (ins_d),
        .ins_e         (ins_e),
        .branch_taken_e(branch_taken_e),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .mdu_busy      (mdu_busy),
        .mdu_done      (mdu_done),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP    = 32'h0;
    localparam logic [31:0] LW8    = {6'h23, 5'd9, 5'd8, 16'd0};
    localparam logic [31:0] ADD8   = {6'h00, 5'd8, 5'd11, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] LW0    = {6'h23, 5'd9, 5'd0, 16'd0};
    localparam logic [31:0] ADD0   = {6'h00, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] MULT   = {6'h00, 5'd8, 5'd9, 10'd0, 6'h18};
    localparam logic [31:0] MULTU  = {6'h00, 5'd8, 5'd9, 10'd0, 6'h19};
    localparam logic [31:0] DIV    = {6'h00, 5'd8, 5'd9, 10'd0, 6'h1A};
    localparam logic [31:0] MFLO   = {16'd0, 5'd10, 5'd0, 6'h12};

    typedef struct {
        string       tag;
        logic [37:0] v;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, passed = 0;
    logic [31:0] exp_cnt = '0;

    function automatic logic [37:0] obs();
        return {stall_f, stall_d, flush_d, flush_e, mdu_busy, mdu_done, stall_cnt};
    endfunction

    task automatic push(input string tag, input logic st, fd, fe, busy, done);
        exp_t e;
        e.tag = tag;
        e.v   = {st, st, fd, fe, busy, done, exp_cnt};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [37:0] o;
        checks++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty: observed no expectation, required one queued");
            return;
        end
        e = sb.pop_front();
        o = obs();
        assert (o === e.v) passed++;
        else $error("FAIL %s: observed st_f/st_d/fl_d/fl_e/busy/done/cnt=%b%b%b%b%b%b/%h required %b%b%b%b%b%b/%h",
                    e.tag, o[37], o[36], o[35], o[34], o[33], o[32], o[31:0],
                    e.v[37], e.v[36], e.v[35], e.v[34], e.v[33], e.v[32], e.v[31:0]);
    endtask

    task automatic step(input string tag, input logic [31:0] d, e, input logic b,
                        input logic st, fd, fe, busy, done);
        @(negedge clk);
        ins_d = d; ins_e = e; branch_taken_e = b;
        push(tag, st, fd, fe, busy, done);
        #1;
        check();
        if (st && reset && exp_cnt != '1) exp_cnt++;
    endtask

    initial begin
        // combinational paths stay live during reset
        ins_d = ADD8; ins_e = LW8;
        #2;
        push("rst_lu", 1, 0, 1, 0, 0);
        check();
        @(negedge clk);
        ins_d = NOP; ins_e = NOP;
        #1;
        push("rst_idle", 0, 0, 0, 0, 0);
        check();
        @(negedge clk);
        reset = 1'b1;

        step("lu",       ADD8, LW8,  0, 1, 0, 1, 0, 0);
        step("lu_after", NOP,  NOP,  0, 0, 0, 0, 0, 0);
        step("lw0",      ADD0, LW0,  0, 0, 0, 0, 0, 0);
        step("br_lu",    ADD8, LW8,  1, 0, 1, 1, 0, 0);
        step("br_after", NOP,  NOP,  0, 0, 0, 0, 0, 0);

        step("mult_e",   MFLO, MULT, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("mflo_busy", MFLO, NOP, 0, 1, 0, 1, 1, 0);
        step("mflo_rel", MFLO, NOP,  0, 0, 0, 0, 0, 1);
        step("mult_idle", NOP, NOP,  0, 0, 0, 0, 0, 0);

        step("multu_br", NOP,  MULTU, 1, 0, 1, 1, 0, 0);
        step("mb1",      NOP,  NOP,  0, 0, 0, 0, 1, 0);
        step("mb2_div",  NOP,  DIV,  0, 0, 0, 0, 1, 0);
        step("mb3",      NOP,  NOP,  0, 0, 0, 0, 1, 0);
        step("mb4",      NOP,  NOP,  0, 0, 0, 0, 1, 0);
        step("mb5",      NOP,  NOP,  0, 0, 0, 0, 1, 0);
        step("mb_done",  NOP,  NOP,  0, 0, 0, 0, 0, 1);
        step("mb_idle",  NOP,  NOP,  0, 0, 0, 0, 0, 0);

        step("div_e",    NOP,  DIV,  0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step("div_busy", NOP, NOP, 0, 0, 0, 0, 1, 0);
        reset = 1'b0;
        exp_cnt = '0;
        #1;
        push("div_abort", 0, 0, 0, 0, 0);
        check();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++)
            step("no_done", NOP, NOP, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.stall_cnt_q;
        exp_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++)
            step("sat", ADD8, LW8, 0, 1, 0, 1, 0, 0);
        step("sat_hold", NOP, NOP, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
